// File: rtl/ppu_issue_arbiter.sv
// Round-robin issue of requester ops into one shared PPU pipeline.
// Tracks in-flight requester IDs and returns tagged results via a FIFO.
module ppu_issue_arbiter #(
  parameter int N_REQ      = 4,
  parameter int OP_SIZE    = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ*OP_SIZE-1:0] req_op_i,
  output logic [N_REQ-1:0]         req_ready_o,
  input  logic                     ppu_stall_i,
  output logic                     ppu_valid_o,
  output logic [OP_SIZE-1:0]       ppu_op_o,
  input  logic                     ppu_valid_i,
  input  logic [DATA_W-1:0]        ppu_data_i,
  output logic                     resp_valid_o,
  output logic [$clog2(N_REQ)-1:0] resp_id_o,
  output logic [DATA_W-1:0]        resp_data_o,
  input  logic                     resp_ready_i,
  output logic                     busy_o,
  output logic                     err_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [IW-1:0]      ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ppu_valid_q, ppu_valid_d;
  logic [OP_SIZE-1:0] ppu_op_q, ppu_op_d;
  logic               err_q, err_d;

  logic [AW:0]        tq_wr_q, tq_wr_d;
  logic [AW:0]        tq_rd_q, tq_rd_d;
  logic [IW-1:0]      tq_mem_q [FIFO_DEPTH];
  logic [IW-1:0]      tq_mem_d [FIFO_DEPTH];

  logic [AW:0]        rf_wr_q, rf_wr_d;
  logic [AW:0]        rf_rd_q, rf_rd_d;
  logic [IW-1:0]      rf_id_q [FIFO_DEPTH];
  logic [IW-1:0]      rf_id_d [FIFO_DEPTH];
  logic [DATA_W-1:0]  rf_dat_q [FIFO_DEPTH];
  logic [DATA_W-1:0]  rf_dat_d [FIFO_DEPTH];

  logic               gnt_found;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      scan_idx;
  logic               issue_en;
  logic               xfer;
  logic               tq_empty;
  logic               rf_empty;
  logic               res_push;
  logic               resp_pop;
  logic [IW-1:0]      res_id;

  // Rotating priority scan starting at ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IW'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_found && req_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign tq_empty = (tq_wr_q == tq_rd_q);
  assign rf_empty = (rf_wr_q == rf_rd_q);

  assign issue_en = !rst
                  && gnt_found
                  && (cnt_q < CW'(FIFO_DEPTH))
                  && !ppu_stall_i;
  assign xfer     = issue_en;

  always_comb begin
    req_ready_o = '0;
    if (issue_en) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  assign res_push = ppu_valid_i && !tq_empty;
  assign resp_pop = !rf_empty && resp_ready_i;
  assign res_id   = tq_mem_q[tq_rd_q[AW-1:0]];

  always_comb begin
    ptr_d       = ptr_q;
    ppu_valid_d = 1'b0;
    ppu_op_d    = ppu_op_q;
    tq_wr_d     = tq_wr_q;
    tq_mem_d    = tq_mem_q;
    if (xfer) begin
      ptr_d    = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      ppu_valid_d = 1'b1;
      ppu_op_d = req_op_i[gnt_idx*OP_SIZE +: OP_SIZE];
      tq_mem_d[tq_wr_q[AW-1:0]] = gnt_idx;
      tq_wr_d  = tq_wr_q + 1'b1;
    end
  end

  always_comb begin
    tq_rd_d  = tq_rd_q;
    rf_wr_d  = rf_wr_q;
    rf_id_d  = rf_id_q;
    rf_dat_d = rf_dat_q;
    err_d    = err_q;
    if (res_push) begin
      tq_rd_d  = tq_rd_q + 1'b1;
      rf_id_d[rf_wr_q[AW-1:0]]  = res_id;
      rf_dat_d[rf_wr_q[AW-1:0]] = ppu_data_i;
      rf_wr_d  = rf_wr_q + 1'b1;
    end
    // A result with nothing in flight has no owner; drop it and flag.
    if (ppu_valid_i && tq_empty) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    rf_rd_d = rf_rd_q;
    cnt_d   = cnt_q;
    if (resp_pop) begin
      rf_rd_d = rf_rd_q + 1'b1;
    end
    unique case ({xfer, resp_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      cnt_q       <= '0;
      ppu_valid_q <= 1'b0;
      ppu_op_q    <= '0;
      err_q       <= 1'b0;
      tq_wr_q     <= '0;
      tq_rd_q     <= '0;
      rf_wr_q     <= '0;
      rf_rd_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tq_mem_q[i] <= '0;
        rf_id_q[i]  <= '0;
        rf_dat_q[i] <= '0;
      end
    end else begin
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ppu_valid_q <= ppu_valid_d;
      ppu_op_q    <= ppu_op_d;
      err_q       <= err_d;
      tq_wr_q     <= tq_wr_d;
      tq_rd_q     <= tq_rd_d;
      rf_wr_q     <= rf_wr_d;
      rf_rd_q     <= rf_rd_d;
      tq_mem_q    <= tq_mem_d;
      rf_id_q     <= rf_id_d;
      rf_dat_q    <= rf_dat_d;
    end
  end

  assign ppu_valid_o  = ppu_valid_q;
  assign ppu_op_o     = ppu_op_q;
  assign resp_valid_o = !rf_empty;
  assign resp_id_o    = rf_empty ? '0 : rf_id_q[rf_rd_q[AW-1:0]];
  assign resp_data_o  = rf_empty ? '0 : rf_dat_q[rf_rd_q[AW-1:0]];
  assign busy_o       = (cnt_q != '0) | ppu_valid_q;
  assign err_o        = err_q;

endmodule

// File: doc/ppu_issue_arbiter.md
# ppu_issue_arbiter

Shares one PPU pipeline among `N_REQ` requesters. It grants the pipeline round-robin and issues the winning op to the PPU. It tracks the requester ID of every in-flight op and returns each PPU result, tagged with its requester ID, through a credit-protected response FIFO. It sits between the requester ports and the PPU control/datapath, and drives the PPU's `valid_i`/`op` inputs.

## Interface
- `N_REQ`, 4: number of requesters, ≥2.
- `OP_SIZE`, 8: op width, same as the PPU op width.
- `DATA_W`, 32: PPU result width.
- `FIFO_DEPTH`, 4: max outstanding ops (in PPU plus buffered), power of two.
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `req_valid_i` in N_REQ: per-requester op valid.
- `req_op_i` in N_REQ*OP_SIZE: requester i op at bits [i*OP_SIZE +: OP_SIZE].
- `req_ready_o` out N_REQ: one-hot-or-zero grant; transfer when valid & ready.
- `ppu_stall_i` in 1: PPU stall; blocks new issue.
- `ppu_valid_o` out 1: op valid to the PPU (registered).
- `ppu_op_o` out OP_SIZE: op to the PPU (registered).
- `ppu_valid_i` in 1: PPU result valid.
- `ppu_data_i` in DATA_W: PPU result.
- `resp_valid_o` out 1: response available.
- `resp_id_o` out $clog2(N_REQ): requester ID of the response.
- `resp_data_o` out DATA_W: response data.
- `resp_ready_i` in 1: response consumer ready.
- `busy_o` out 1: ops outstanding or issuing.
- `err_o` out 1: sticky protocol error.

## Operation
- **State:**
  - `ptr`: round-robin pointer.
  - `cnt`: credit counter, 0..FIFO_DEPTH.
  - Tag queue: IDs, depth FIFO_DEPTH.
  - Result FIFO: {id, data}, depth FIFO_DEPTH.
- **Issue enable:** `req_valid_i != 0` & `cnt < FIFO_DEPTH` & `!ppu_stall_i`.
  - `cnt` is the registered value.
  - A same-cycle response pop does not free a credit that cycle.
- **Grant:**
  - The first asserted `req_valid_i` scanning `ptr`, `ptr+1`, … mod N_REQ.
  - `req_ready_o` asserts only that bit, and only when issue is enabled.
  - `req_ready_o` is combinational from the current inputs and state.
- **On transfer by requester g:**
  - `ptr <= (g+1) mod N_REQ`.
  - Push g into the tag queue.
  - `ppu_valid_o <= 1`, `ppu_op_o <= req_op_i[g]`.
- **No transfer:**
  - `ptr` holds.
  - `ppu_valid_o <= 0`.
  - `ppu_op_o` holds its last value.
- **On `ppu_valid_i`:**
  - Pop the tag queue head as the ID.
  - Push {ID, `ppu_data_i`} into the result FIFO.
- **Spurious result:** if `ppu_valid_i` arrives with the tag queue empty, discard the result and set `err_o` = 1 until `rst`.
- **Response side:**
  - `resp_valid_o` = result FIFO not empty.
  - `resp_id_o`/`resp_data_o` = FIFO head, first-word-fall-through.
  - Pop on `resp_valid_o & resp_ready_i`.
- **Credits:**
  - `cnt` +1 on transfer, −1 on response pop; unchanged when both happen in one cycle.
  - The tag queue and result FIFO can never overflow because their occupancies are ≤ `cnt`.
- **busy_o:** `(cnt != 0) | ppu_valid_o`.
- **Ordering:** the PPU is in-order, so responses leave in global issue order.
- **Reset values:**
  - `ptr`=0, `cnt`=0, both queues empty.
  - `ppu_valid_o`=0, `ppu_op_o`=0.
  - `resp_valid_o`=0, `resp_id_o`=0, `resp_data_o`=0.
  - `busy_o`=0, `err_o`=0, `req_ready_o`=0.
- **Reset mid-operation:** all in-flight tags and buffered results are dropped. The PPU shares `rst`, so its valid pipeline clears in the same cycle.

## Timing
- Transfer at edge t → `ppu_valid_o`/`ppu_op_o` valid during cycle t+1, for exactly one cycle per transfer.
- Back-to-back: one transfer per cycle while credits remain.
- `ppu_valid_i` sampled at edge t → `resp_valid_o` high from cycle t+1. There is no combinational path from `ppu_valid_i` to `resp_valid_o`.
- Response pop at edge t → `cnt` decrements at t. A requester can transfer during cycle t+1 (sampled at edge t+1).
- End-to-end latency = 1 (issue register) + PPU latency + 1 (result FIFO).
- `ppu_stall_i` acts combinationally on `req_ready_o` in the same cycle. It does not cancel an op already in `ppu_valid_o`.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `req_valid_i`=1 → `req_ready_o`=0, `ppu_valid_o`=0, `resp_valid_o`=0, `busy_o`=0, `err_o`=0.
- **Single requester:** requester 2 holds op 0x5A, `resp_ready_i`=0, PPU latency 3.
  - Four transfers on consecutive cycles.
  - `ppu_op_o`=0x5A one cycle after each transfer.
  - `req_ready_o[2]` then drops to 0 with `cnt`=4.
- **All requesters:** all 4 requesters continuously valid, ops 0x10+i, `resp_ready_i`=1.
  - Grant order 0,1,2,3,0,1.
  - `resp_id_o` sequence 0,1,2,3,0,1 with matching data.
- **Stall:** `ppu_stall_i`=1 for 5 cycles with requests pending → `req_ready_o`=0 and `ppu_valid_o`=0 throughout. Issue resumes the first cycle `ppu_stall_i`=0, starting at the current `ptr`.
- **Credit return:** reach `cnt`=4, then pulse `resp_ready_i` for one cycle (edge t).
  - No transfer during cycle t.
  - Exactly one transfer at edge t+1.
  - `cnt` returns to 4.
- **Spurious result:** idle block, `ppu_valid_i`=1 with `ppu_data_i`=0xDEAD → `err_o`=1 from the next cycle and stays 1; `resp_valid_o` stays 0; `rst` clears `err_o`.
